// File: rtl/online_mult_pkg.sv
// Shared constants for the online multiplier digit stream: digit width,
// counter scaling and the driver state encoding.
package online_mult_pkg;

  // Radix-4 digits: two bits per digit on every channel.
  localparam int DIGIT_W = 2;

  // cnt_master is the digit index scaled by four (two zero LSBs).
  localparam int CNT_SHIFT = 2;

  // Driver state encoding, kept as plain constants so older code can
  // compare against them directly.
  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] SEND     = 3'd1;
  localparam logic [2:0] WAIT_OUT = 3'd2;
  localparam logic [2:0] DONE     = 3'd3;

  typedef logic [DIGIT_W-1:0] digit_t;

endpackage

// File: rtl/online_digit_stream_driver_if.sv
// Digit handshake bundle between the stream driver (master) and the
// multiplier controller (slave): x/y operand digits out, z result digits back.
interface online_digit_stream_driver_if;
  import online_mult_pkg::*;

  digit_t x_value;
  digit_t y_value;
  digit_t z_value;
  logic   data_x_vld;
  logic   data_x_rdy;
  logic   data_y_vld;
  logic   data_y_rdy;
  logic   data_out_vld;
  logic   data_out_rdy;

  modport master (
    output x_value, y_value, data_x_vld, data_y_vld, data_out_rdy,
    input  data_x_rdy, data_y_rdy, z_value, data_out_vld
  );

  modport slave (
    input  x_value, y_value, data_x_vld, data_y_vld, data_out_rdy,
    output data_x_rdy, data_y_rdy, z_value, data_out_vld
  );

endinterface

// File: rtl/online_digit_shifter.sv
// MSB-first digit shift register with parallel load. Each shift moves the
// word up by one digit and inserts shift_in at the bottom. The tap exposes
// the top TAP_W bits: one digit for operand streaming, the full word when
// used to collect a result.
module online_digit_shifter
  import online_mult_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int TAP_W = DIGIT_W
) (
  input  logic             clk,
  input  logic             asyn_reset,
  input  logic             load_en,
  input  logic [WIDTH-1:0] load_data,
  input  logic             shift_en,
  input  digit_t           shift_in,
  output logic [TAP_W-1:0] tap
);

  logic [WIDTH-1:0] shreg_reg;
  logic [WIDTH-1:0] shifted;

  generate
    if (WIDTH > DIGIT_W) begin : g_wide
      assign shifted = {shreg_reg[WIDTH-DIGIT_W-1:0], shift_in};
    end else begin : g_single
      // A one-digit register is simply replaced on every shift.
      assign shifted = shift_in;
    end
  endgenerate

  // Load has priority over shift; reset clears the whole word.
  always_ff @(posedge clk) begin
    if (asyn_reset) begin
      shreg_reg <= '0;
    end else if (load_en) begin
      shreg_reg <= load_data;
    end else if (shift_en) begin
      shreg_reg <= shifted;
    end
  end

  assign tap = shreg_reg[WIDTH-1 -: TAP_W];

endmodule

// File: rtl/online_digit_stream_driver.sv
// Streams two operand words MSB-first as 2-bit digits over independent x/y
// handshakes, collects one result digit per digit pair, reassembles the
// result word and maintains the cnt_master digit counter.
module online_digit_stream_driver
  import online_mult_pkg::*;
#(
  parameter int DIGITS         = 8,
  parameter int RAM_ADDR_WIDTH = 7
) (
  input  logic                        clk,
  input  logic                        asyn_reset,
  input  logic                        start,
  input  logic [2*DIGITS-1:0]         op_x,
  input  logic [2*DIGITS-1:0]         op_y,
  output logic                        op_rdy,
  online_digit_stream_driver_if.master bus,
  output logic [RAM_ADDR_WIDTH+1:0]   cnt_master,
  output logic [2*DIGITS-1:0]         result,
  output logic                        result_vld
);

  localparam int W  = DIGIT_W * DIGITS;
  localparam int CW = RAM_ADDR_WIDTH + CNT_SHIFT;
  localparam logic [RAM_ADDR_WIDTH-1:0] LAST_IDX = RAM_ADDR_WIDTH'(DIGITS - 1);

  logic [2:0]                state_reg, state_next;
  logic                      x_vld_reg, x_vld_next;
  logic                      y_vld_reg, y_vld_next;
  logic                      out_rdy_reg, out_rdy_next;
  logic                      result_vld_reg, result_vld_next;
  logic                      op_rdy_reg, op_rdy_next;
  logic [RAM_ADDR_WIDTH-1:0] digit_idx_reg, digit_idx_next;
  logic [CW-1:0]             cnt_reg, cnt_next;

  logic load_en;
  logic op_shift_en;
  logic res_shift_en;
  logic x_xfer;
  logic y_xfer;
  logic out_xfer;

  logic [W-1:0] op_word  [2];
  digit_t       op_digit [2];

  assign x_xfer   = x_vld_reg && bus.data_x_rdy;
  assign y_xfer   = y_vld_reg && bus.data_y_rdy;
  assign out_xfer = out_rdy_reg && bus.data_out_vld;

  assign op_word[0] = op_x;
  assign op_word[1] = op_y;

  // Index 0 carries x, index 1 carries y; both advance together.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_op
      online_digit_shifter #(
        .WIDTH (W),
        .TAP_W (DIGIT_W)
      ) u_op_shifter (
        .clk        (clk),
        .asyn_reset (asyn_reset),
        .load_en    (load_en),
        .load_data  (op_word[gi]),
        .shift_en   (op_shift_en),
        .shift_in   ('0),
        .tap        (op_digit[gi])
      );
    end
  endgenerate

  // Result collector: cleared on job start, z digits enter at the bottom so
  // the first-received digit ends up in the MSB position.
  online_digit_shifter #(
    .WIDTH (W),
    .TAP_W (W)
  ) u_result_shifter (
    .clk        (clk),
    .asyn_reset (asyn_reset),
    .load_en    (load_en),
    .load_data  ('0),
    .shift_en   (res_shift_en),
    .shift_in   (bus.z_value),
    .tap        (result)
  );

  // Next-state and handshake control for one job.
  always_comb begin
    state_next      = state_reg;
    x_vld_next      = x_vld_reg;
    y_vld_next      = y_vld_reg;
    out_rdy_next    = out_rdy_reg;
    result_vld_next = result_vld_reg;
    digit_idx_next  = digit_idx_reg;
    load_en         = 1'b0;
    op_shift_en     = 1'b0;
    res_shift_en    = 1'b0;

    case (state_reg)
      IDLE: begin
        if (start) begin
          load_en        = 1'b1;
          digit_idx_next = '0;
          x_vld_next     = 1'b1;
          y_vld_next     = 1'b1;
          state_next     = SEND;
        end
      end

      SEND: begin
        // Each channel drops its valid on its own transfer edge.
        if (x_xfer) x_vld_next = 1'b0;
        if (y_xfer) y_vld_next = 1'b0;
        if (!x_vld_next && !y_vld_next) begin
          out_rdy_next = 1'b1;
          state_next   = WAIT_OUT;
        end
      end

      WAIT_OUT: begin
        if (out_xfer) begin
          res_shift_en = 1'b1;
          out_rdy_next = 1'b0;
          if (digit_idx_reg == LAST_IDX) begin
            result_vld_next = 1'b1;
            state_next      = DONE;
          end else begin
            digit_idx_next = digit_idx_reg + 1'b1;
            op_shift_en    = 1'b1;
            x_vld_next     = 1'b1;
            y_vld_next     = 1'b1;
            state_next     = SEND;
          end
        end
      end

      DONE: begin
        result_vld_next = 1'b0;
        state_next      = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase

    cnt_next    = {digit_idx_next, {CNT_SHIFT{1'b0}}};
    op_rdy_next = (state_next == IDLE);
  end

  // State and output registers; reset abandons any job in flight.
  always_ff @(posedge clk) begin
    if (asyn_reset) begin
      state_reg      <= IDLE;
      x_vld_reg      <= 1'b0;
      y_vld_reg      <= 1'b0;
      out_rdy_reg    <= 1'b0;
      result_vld_reg <= 1'b0;
      op_rdy_reg     <= 1'b1;
      digit_idx_reg  <= '0;
      cnt_reg        <= '0;
    end else begin
      state_reg      <= state_next;
      x_vld_reg      <= x_vld_next;
      y_vld_reg      <= y_vld_next;
      out_rdy_reg    <= out_rdy_next;
      result_vld_reg <= result_vld_next;
      op_rdy_reg     <= op_rdy_next;
      digit_idx_reg  <= digit_idx_next;
      cnt_reg        <= cnt_next;
    end
  end

  assign op_rdy           = op_rdy_reg;
  assign cnt_master       = cnt_reg;
  assign result_vld       = result_vld_reg;
  assign bus.x_value      = op_digit[0];
  assign bus.y_value      = op_digit[1];
  assign bus.data_x_vld   = x_vld_reg;
  assign bus.data_y_vld   = y_vld_reg;
  assign bus.data_out_rdy = out_rdy_reg;

endmodule

// File: doc/online_digit_stream_driver.md
Name: online_digit_stream_driver

Overview:
- Producer/collector on the far side of the multiplier controller's digit handshake.
- Accepts two parallel operand words and streams them MSB-first as 2-bit digits on the x/y vld/rdy channels.
- Collects one 2-bit result digit per digit pair on the data_out vld/rdy channel and reassembles the result word.
- Also generates the cnt_master digit counter that the controller consumes.

Parameters:
- DIGITS, 8, digits per operand and per result; legal range 1..2^RAM_ADDR_WIDTH.
- RAM_ADDR_WIDTH, 7, digit-index width; cnt_master width is RAM_ADDR_WIDTH+2.

Ports:
- clk  in  1  single clock, all logic on rising edge.
- asyn_reset  in  1  reset, synchronous, active-high. Name is kept for codebase consistency; it is sampled only on the clk edge.
- start  in  1  job request; accepted only when op_rdy=1.
- op_x  in  2*DIGITS  x operand; digit 0 (MSB) is bits [2*DIGITS-1:2*DIGITS-2].
- op_y  in  2*DIGITS  y operand, same layout as op_x.
- op_rdy  out  1  high in IDLE.
- x_value  out  2  current x digit.
- y_value  out  2  current y digit.
- data_x_vld  out  1  x digit valid.
- data_x_rdy  in  1  consumer ready for x.
- data_y_vld  out  1  y digit valid.
- data_y_rdy  in  1  consumer ready for y.
- z_value  in  2  result digit from the multiplier.
- data_out_vld  in  1  result digit valid.
- data_out_rdy  out  1  driver ready for a result digit.
- cnt_master  out  RAM_ADDR_WIDTH+2  equals {digit_idx, 2'b00}.
- result  out  2*DIGITS  assembled result; first-received digit ends up in the MSB position.
- result_vld  out  1  one-cycle pulse when result is complete.

Behaviour:
- Reset sampled high:
  - State goes to IDLE.
  - All of the following are 0 from the following edge: data_x_vld, data_y_vld, data_out_rdy, result_vld, result, cnt_master, x_value, y_value, digit_idx.
  - Reset mid-job abandons the job; no partial result_vld is issued.
- All outputs are registered; no combinational path from any input to any output.
- A transfer occurs on a clk edge where vld&&rdy for that channel.
- The x and y channels handshake independently within a digit. The driver does not advance until both have transferred.
- States: IDLE, SEND, WAIT_OUT, DONE.
- IDLE:
  - op_rdy=1.
  - On start=1: latch op_x/op_y into shift registers, clear result and digit_idx, and drive digit 0 onto x_value/y_value.
  - In the same edge, set data_x_vld=data_y_vld=1 and go to SEND. Next cycle op_rdy=0.
- SEND:
  - data_x_vld drops on the edge of the x transfer; data_y_vld drops on the edge of the y transfer. Simultaneous transfers drop both on one edge.
  - x_value/y_value hold stable while the corresponding vld is high.
  - When both have transferred (including the edge that completes the second): set data_out_rdy=1 and go to WAIT_OUT.
- WAIT_OUT:
  - On data_out_vld&&data_out_rdy: result <= {result[2*DIGITS-3:0], z_value} and data_out_rdy <= 0.
  - If digit_idx==DIGITS-1, go to DONE.
  - Otherwise: digit_idx += 1, cnt_master += 4, shift the next operand digit onto x_value/y_value, set both vld=1, and go to SEND.
  - data_out_vld while data_out_rdy=0 is ignored, in any state.
- DONE:
  - result_vld=1 for exactly one cycle, then IDLE.
  - result and cnt_master hold until the next accepted start.
- start outside IDLE is ignored; it is not queued.
- Latency per digit with an always-ready consumer: 1 edge SEND, then 1 edge WAIT_OUT after data_out_vld rises.
- Handshake rules:
  - vld never deasserts without a transfer.
  - No x/y digit is presented before the previous result digit has been accepted.
- Width rules:
  - digit_idx wraps never; it is bounded by DIGITS-1.
  - cnt_master low 2 bits are always 00.
- DIGITS=1: a single SEND/WAIT_OUT pass, then DONE.

Decomposition:
- Shared package (online_mult_pkg):
  - State encoding constants IDLE/SEND/WAIT_OUT/DONE as 3-bit parameters.
  - DIGIT_W=2.
  - The cnt_master shift constant (2).
- One natural sub-module: online_digit_shifter, a parameterised MSB-first load/shift register with a parallel-load port. It is instantiated for op_x and op_y; result uses the same module in shift-in mode.

Test Plan:
- Always-ready consumer model:
  - Stimulus: DIGITS=4, op_x=8'b01_00_11_01, op_y=8'b00_01_01_11, z digits 11,01,00,10.
  - Required: x_value sequence 01,00,11,01; y_value sequence 00,01,01,11; cnt_master 0,4,8,12; result=8'b11_01_00_10; one result_vld pulse.
- x backpressure:
  - Stimulus: data_x_rdy held low 5 cycles on digit 1, data_y_rdy high.
  - Required: data_x_vld and x_value stable through the stall; y transfers once; data_out_rdy only after the x transfer; final result unchanged.
- Output stall:
  - Stimulus: data_out_vld held low 10 cycles on digit 2.
  - Required: data_x_vld=data_y_vld=0 throughout the stall; data_out_rdy stays 1; no extra result shift.
- Start while busy:
  - Stimulus: start pulsed in SEND with different operands.
  - Required: ignored; op_rdy=0; the original job completes with the original result.
- Reset mid-op:
  - Stimulus: asyn_reset high for 1 cycle in WAIT_OUT at digit 2.
  - Required: next edge all outputs 0 and op_rdy=1; no result_vld; a new job completes correctly.
- DIGITS=1 and back-to-back jobs:
  - Stimulus: start asserted the cycle after result_vld.
  - Required: accepted immediately; cnt_master restarts at 0.
